datapath_seq: RTL

DATAPATH_SEQ -- requirements
Module: datapath_seq

---
 rtl/datapath_seq_pkg.sv | 36 +++
 rtl/datapath_seq_if.sv | 35 +++
 rtl/datapath_seq_prog_mem.sv | 26 ++
 rtl/datapath_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/datapath_seq_pkg.sv
// Shared types for datapath_seq: opcodes, FSM states, instruction layout.
package datapath_seq_pkg;

  localparam int unsigned INSTR_W = 25;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned IMM_W   = 8;

  localparam int unsigned OP_LSB  = 23;
  localparam int unsigned RD_LSB  = 18;
  localparam int unsigned RS1_LSB = 13;
  localparam int unsigned RS2_LSB = 8;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [OP_W-1:0] {
    OP_HALT = 2'b00,
    OP_ADD  = 2'b01,
    OP_ADDI = 2'b10,
    OP_BNE  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10
  } state_e;

  typedef struct packed {
    op_e              op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [IMM_W-1:0] imm;
  } instr_t;

endpackage

// File: rtl/datapath_seq_if.sv
// Program-load, run-control and datapath-control bundle for datapath_seq.
interface datapath_seq_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned PROG_DEPTH    = 8
) ();
  localparam int unsigned PC_W = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;

  logic                     prog_we;
  logic [PC_W-1:0]          prog_addr;
  logic [24:0]              prog_wdata;
  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     err;
  logic [PC_W-1:0]          pc;
  logic                     eq;
  logic [ADDRESS_WIDTH-1:0] rs1;
  logic [ADDRESS_WIDTH-1:0] rs2;
  logic [ADDRESS_WIDTH-1:0] rd;
  logic                     RegWrite;
  logic                     ALUsrc;
  logic                     ALUCtrl;
  logic [DATA_WIDTH-1:0]    ImmOp;

  modport master (
    output prog_we, prog_addr, prog_wdata, start, eq,
    input  busy, done, err, pc, rs1, rs2, rd, RegWrite, ALUsrc, ALUCtrl, ImmOp
  );

  modport slave (
    input  prog_we, prog_addr, prog_wdata, start, eq,
    output busy, done, err, pc, rs1, rs2, rd, RegWrite, ALUsrc, ALUCtrl, ImmOp
  );
endinterface

// File: rtl/datapath_seq_prog_mem.sv
// seq_prog_mem: program buffer, async reset to HALT, one write port, one combinational read port.
module seq_prog_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 25
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];

  // Storage: cleared on reset, written on the clock edge when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/datapath_seq.sv
// datapath_seq: tiny program sequencer driving register-file/ALU controls.
// Optional feature: define DATAPATH_SEQ_STEP_LIMIT_EN to abort runs after STEP_LIMIT EXEC cycles.
module datapath_seq
  import datapath_seq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned PROG_DEPTH    = 8,
  parameter int unsigned STEP_LIMIT    = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  datapath_seq_if.slave bus
);
  localparam int unsigned PC_W = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;

  state_e                   r_state;
  op_e                      r_op;
  logic [PC_W-1:0]          r_pc;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_err;
  logic                     r_regwrite;
  logic                     r_alusrc;
  logic [ADDRESS_WIDTH-1:0] r_rs1;
  logic [ADDRESS_WIDTH-1:0] r_rs2;
  logic [ADDRESS_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0]    r_immop;

  logic                     w_prog_we;
  logic [INSTR_W-1:0]       w_mem_rdata;
  instr_t                   w_fetch;
  logic [DATA_WIDTH-1:0]    w_fetch_imm;
  logic [PC_W-1:0]          w_next_pc;
  logic                     w_step_abort;

  // Program writes only land while the sequencer is idle.
  assign w_prog_we = bus.prog_we & ~r_busy;

  seq_prog_mem #(
    .DEPTH (PROG_DEPTH),
    .WIDTH (INSTR_W)
  ) u_prog_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_prog_we),
    .i_waddr (bus.prog_addr),
    .i_wdata (bus.prog_wdata),
    .i_raddr (w_next_pc),
    .o_rdata (w_mem_rdata)
  );

  // Next pc; the branch offset is the low bits of the registered sign-extended immediate.
  always_comb begin
    w_next_pc = r_pc;
    case (r_state)
      ST_IDLE: w_next_pc = '0;
      ST_EXEC: if (r_op == OP_BNE) w_next_pc = bus.eq ? r_pc + PC_W'(1) : r_pc + PC_W'(r_immop);
      ST_WB:   w_next_pc = r_pc + PC_W'(1);
      default: w_next_pc = r_pc;
    endcase
  end

  // Fetch the word at the next pc, forwarding a same-cycle idle write so start+write runs it.
  always_comb begin
    w_fetch = instr_t'(w_mem_rdata);
    if (w_prog_we && (bus.prog_addr == w_next_pc)) w_fetch = instr_t'(bus.prog_wdata);
    w_fetch_imm = DATA_WIDTH'(signed'(w_fetch.imm));
  end

`ifdef DATAPATH_SEQ_STEP_LIMIT_EN
  localparam int unsigned STEP_W = $clog2(STEP_LIMIT + 1);
  logic [STEP_W-1:0] r_steps;

  // Count EXEC cycles of the current run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_steps <= '0;
    end else if (r_state == ST_IDLE) begin
      r_steps <= '0;
    end else if (r_state == ST_EXEC) begin
      r_steps <= r_steps + STEP_W'(1);
    end
  end

  assign w_step_abort = (r_state == ST_EXEC) && (r_op != OP_HALT) &&
                        (r_steps == STEP_W'(STEP_LIMIT - 1));
`else
  assign w_step_abort = 1'b0;
`endif

  // Sequencer FSM with all control outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_HALT;
      r_pc       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_regwrite <= 1'b0;
      r_alusrc   <= 1'b0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_immop    <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state  <= ST_EXEC;
            r_busy   <= 1'b1;
            r_pc     <= w_next_pc;
            r_op     <= w_fetch.op;
            r_rs1    <= ADDRESS_WIDTH'(w_fetch.rs1);
            r_rs2    <= ADDRESS_WIDTH'(w_fetch.rs2);
            r_rd     <= ADDRESS_WIDTH'(w_fetch.rd);
            r_immop  <= w_fetch_imm;
            r_alusrc <= (w_fetch.op == OP_ADDI);
          end
        end
        ST_EXEC: begin
          if (w_step_abort || (r_op == OP_HALT)) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_err      <= w_step_abort;
            r_regwrite <= 1'b0;
            r_alusrc   <= 1'b0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_immop    <= '0;
          end else if (r_op == OP_BNE) begin
            r_pc     <= w_next_pc;
            r_op     <= w_fetch.op;
            r_rs1    <= ADDRESS_WIDTH'(w_fetch.rs1);
            r_rs2    <= ADDRESS_WIDTH'(w_fetch.rs2);
            r_rd     <= ADDRESS_WIDTH'(w_fetch.rd);
            r_immop  <= w_fetch_imm;
            r_alusrc <= (w_fetch.op == OP_ADDI);
          end else begin
            r_state    <= ST_WB;
            r_regwrite <= 1'b1;
          end
        end
        ST_WB: begin
          r_state    <= ST_EXEC;
          r_regwrite <= 1'b0;
          r_pc       <= w_next_pc;
          r_op       <= w_fetch.op;
          r_rs1      <= ADDRESS_WIDTH'(w_fetch.rs1);
          r_rs2      <= ADDRESS_WIDTH'(w_fetch.rs2);
          r_rd       <= ADDRESS_WIDTH'(w_fetch.rd);
          r_immop    <= w_fetch_imm;
          r_alusrc   <= (w_fetch.op == OP_ADDI);
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
  assign bus.pc       = r_pc;
  assign bus.rs1      = r_rs1;
  assign bus.rs2      = r_rs2;
  assign bus.rd       = r_rd;
  assign bus.RegWrite = r_regwrite;
  assign bus.ALUsrc   = r_alusrc;
  assign bus.ALUCtrl  = 1'b0;
  assign bus.ImmOp    = r_immop;
endmodule
